// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants, field slices and FSM state type for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // bex tests the status register implicitly
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_ERR  = 2'd2
    } md_state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: instruction taps, multdiv handshake, latch controls.
interface pipeline_hazard_ctrl_if;
    logic [31:0] IR_Decode;
    logic [31:0] IR_Execute;
    logic        br_taken_X;
    logic        data_resultRDY;
    logic        data_exception;

    logic        stall_PC;
    logic        stall_FD;
    logic        stall_DX;
    logic        nop_DX;
    logic        nop_XM;
    logic        flush_FD;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        md_capture;
    logic        md_exception;
    logic        md_busy;
    logic        md_timeout;

    modport master (
        output IR_Decode, IR_Execute, br_taken_X, data_resultRDY, data_exception,
        input  stall_PC, stall_FD, stall_DX, nop_DX, nop_XM, flush_FD,
        input  ctrl_MULT, ctrl_DIV, md_capture, md_exception, md_busy, md_timeout
    );

    modport slave (
        input  IR_Decode, IR_Execute, br_taken_X, data_resultRDY, data_exception,
        output stall_PC, stall_FD, stall_DX, nop_DX, nop_XM, flush_FD,
        output ctrl_MULT, ctrl_DIV, md_capture, md_exception, md_busy, md_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_decode_src_regs.sv
// Combinational source-register decode of one instruction word (up to two sources).
module decode_src_regs
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  src_a,
    output logic [4:0]  src_b,
    output logic        valid_a,
    output logic        valid_b
);

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[11:0];

    always_comb begin
        src_a   = '0;
        src_b   = '0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        case (opcode_of(ir))
            OP_RTYPE: begin
                src_a   = ir[RS_HI:RS_LO];
                src_b   = ir[RT_HI:RT_LO];
                valid_a = 1'b1;
                valid_b = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                src_a   = ir[RS_HI:RS_LO];
                valid_a = 1'b1;
            end
            OP_SW: begin
                src_a   = ir[RS_HI:RS_LO];
                src_b   = ir[RD_HI:RD_LO];
                valid_a = 1'b1;
                valid_b = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                src_a   = ir[RD_HI:RD_LO];
                src_b   = ir[RS_HI:RS_LO];
                valid_a = 1'b1;
                valid_b = 1'b1;
            end
            OP_JR: begin
                src_a   = ir[RD_HI:RD_LO];
                valid_a = 1'b1;
            end
            OP_BEX: begin
                src_a   = REG_STATUS;
                valid_a = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, taken branch and multdiv start/wait/capture sequencing.
// Optional multdiv watchdog (counter, ERR state, sticky md_timeout) enabled by MULTDIV_TIMEOUT_EN.
//
// state   | meaning
// MD_IDLE | no multdiv in flight; issues start pulse when mul/div sits in Execute
// MD_BUSY | waiting for data_resultRDY with front end frozen
// MD_ERR  | watchdog expired; one capture cycle on the error path (timeout build only)
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
`ifdef MULTDIV_TIMEOUT_EN
#(
    parameter int unsigned MD_TIMEOUT = 40
)
`endif
(
    input  logic                   clock,
    input  logic                   resetn,
    pipeline_hazard_ctrl_if.slave  hz
);

    md_state_t state, state_d;

    logic [4:0] src_a, src_b;
    logic       valid_a, valid_b;

    decode_src_regs u_decode_src_regs (
        .ir      (hz.IR_Decode),
        .src_a   (src_a),
        .src_b   (src_b),
        .valid_a (valid_a),
        .valid_b (valid_b)
    );

    logic [4:0] ex_op, ex_rd, ex_alu;
    logic       is_mul_x, is_div_x, md_issue, load_use;

    assign ex_op    = opcode_of(hz.IR_Execute);
    assign ex_rd    = hz.IR_Execute[RD_HI:RD_LO];
    assign ex_alu   = hz.IR_Execute[ALU_HI:ALU_LO];
    assign is_mul_x = (ex_op == OP_RTYPE) && (ex_alu == ALU_MUL);
    assign is_div_x = (ex_op == OP_RTYPE) && (ex_alu == ALU_DIV);
    assign md_issue = is_mul_x | is_div_x;

    // r0 is hardwired, so a load targeting it never creates a real dependency
    assign load_use = (ex_op == OP_LW) && (ex_rd != 5'd0) &&
                      ((valid_a && (src_a == ex_rd)) || (valid_b && (src_b == ex_rd)));

    logic unused_ir_bits;
    assign unused_ir_bits = ^{hz.IR_Execute[21:7], hz.IR_Execute[1:0]};

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MD_TIMEOUT + 1);

    logic [CNT_W-1:0] md_cnt;
    logic             timeout_q;
    logic             cnt_expired;

    // this BUSY cycle is the last one allowed
    assign cnt_expired = (md_cnt == CNT_W'(MD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            md_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == MD_IDLE && md_issue)
                md_cnt <= '0;
            else if (state == MD_BUSY && !hz.data_resultRDY)
                md_cnt <= md_cnt + 1'b1;
            if (state == MD_BUSY && !hz.data_resultRDY && cnt_expired)
                timeout_q <= 1'b1;
        end
    end

    assign hz.md_timeout = resetn & timeout_q;
`else
    assign hz.md_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= MD_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            MD_IDLE: begin
                if (md_issue)
                    state_d = MD_BUSY;
            end
            MD_BUSY: begin
                if (hz.data_resultRDY)
                    state_d = MD_IDLE;
`ifdef MULTDIV_TIMEOUT_EN
                else if (cnt_expired)
                    state_d = MD_ERR;
`endif
            end
            default: state_d = MD_IDLE;
        endcase
    end

    logic stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd;
    logic ctrl_mult, ctrl_div, md_capture, md_exception, md_busy;

    always_comb begin
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        stall_dx     = 1'b0;
        nop_dx       = 1'b0;
        nop_xm       = 1'b0;
        flush_fd     = 1'b0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        md_capture   = 1'b0;
        md_exception = 1'b0;
        md_busy      = 1'b0;
        if (resetn) begin
            case (state)
                MD_IDLE: begin
                    if (md_issue) begin
                        stall_pc  = 1'b1;
                        stall_fd  = 1'b1;
                        stall_dx  = 1'b1;
                        nop_xm    = 1'b1;
                        ctrl_mult = is_mul_x;
                        ctrl_div  = is_div_x;
                    end else if (hz.br_taken_X) begin
                        flush_fd = 1'b1;
                        nop_dx   = 1'b1;
                    end else if (load_use) begin
                        stall_pc = 1'b1;
                        stall_fd = 1'b1;
                        nop_dx   = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (!hz.data_resultRDY) begin
                        stall_pc = 1'b1;
                        stall_fd = 1'b1;
                        stall_dx = 1'b1;
                        nop_xm   = 1'b1;
                    end else begin
                        md_capture   = 1'b1;
                        md_exception = hz.data_exception;
                    end
                end
`ifdef MULTDIV_TIMEOUT_EN
                MD_ERR: begin
                    md_capture   = 1'b1;
                    md_exception = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign hz.stall_PC     = stall_pc;
    assign hz.stall_FD     = stall_fd;
    assign hz.stall_DX     = stall_dx;
    assign hz.nop_DX       = nop_dx;
    assign hz.nop_XM       = nop_xm;
    assign hz.flush_FD     = flush_fd;
    assign hz.ctrl_MULT    = ctrl_mult;
    assign hz.ctrl_DIV     = ctrl_div;
    assign hz.md_capture   = md_capture;
    assign hz.md_exception = md_exception;
    assign hz.md_busy      = md_busy;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    pipeline_hazard_ctrl_if hz();

`ifdef MULTDIV_TIMEOUT_EN
    localparam int TMO_LIMIT = 4;
    pipeline_hazard_ctrl #(.MD_TIMEOUT(TMO_LIMIT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .hz     (hz)
    );
`else
    pipeline_hazard_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .hz     (hz)
    );
`endif

    always #5 clock = ~clock;

    // output vector bit masks
    localparam logic [11:0] M_SPC  = 12'h800;
    localparam logic [11:0] M_SFD  = 12'h400;
    localparam logic [11:0] M_SDX  = 12'h200;
    localparam logic [11:0] M_NDX  = 12'h100;
    localparam logic [11:0] M_NXM  = 12'h080;
    localparam logic [11:0] M_FFD  = 12'h040;
    localparam logic [11:0] M_CMUL = 12'h020;
    localparam logic [11:0] M_CDIV = 12'h010;
    localparam logic [11:0] M_CAP  = 12'h008;
    localparam logic [11:0] M_EXC  = 12'h004;
    localparam logic [11:0] M_BSY  = 12'h002;
    localparam logic [11:0] M_TMO  = 12'h001;
    localparam logic [11:0] FREEZE = M_SPC | M_SFD | M_SDX | M_NXM;
    localparam logic [11:0] LDUSE  = M_SPC | M_SFD | M_NDX;
    localparam logic [11:0] BRFL   = M_FFD | M_NDX;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %03h want %03h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {hz.stall_PC, hz.stall_FD, hz.stall_DX, hz.nop_DX, hz.nop_XM, hz.flush_FD,
                hz.ctrl_MULT, hz.ctrl_DIV, hz.md_capture, hz.md_exception, hz.md_busy,
                hz.md_timeout};
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt,
                                       input int alu);
        logic [4:0] f_op, f_rd, f_rs, f_rt, f_alu;
        f_op = op[4:0]; f_rd = rd[4:0]; f_rs = rs[4:0]; f_rt = rt[4:0]; f_alu = alu[4:0];
        return {f_op, f_rd, f_rs, f_rt, 5'b00000, f_alu, 2'b00};
    endfunction

    // called at posedge+1: check mid-cycle, then move to next posedge+1
    task automatic cyc(input string tag, input logic [11:0] exp);
        #4;
        check_eq(tag, outs(), exp);
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit m_wait, m_err, m_tmo;
    int m_cnt;

    function automatic bit reads_reg(input logic [31:0] ir, input int r);
        int op, rd, rs, rt;
        op = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]); rt = int'(ir[16:12]);
        case (op)
            0:       return (rs == r) || (rt == r);
            5, 8:    return rs == r;
            7:       return (rs == r) || (rd == r);
            2, 6:    return (rd == r) || (rs == r);
            4:       return rd == r;
            22:      return r == 30;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int md_kind(input logic [31:0] ir);
        if (ir[31:27] != 5'd0) return 0;
        if (ir[6:2] == 5'd6) return 1;
        if (ir[6:2] == 5'd7) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_tmo = 0; m_cnt = 0;
    endtask

    task automatic model_step(output logic [11:0] exp);
        int  kind, ld_rd;
        bit  issuing, lu;
        kind    = md_kind(hz.IR_Execute);
        issuing = !m_wait && !m_err && (kind != 0);
        ld_rd   = int'(hz.IR_Execute[26:22]);
        lu      = (hz.IR_Execute[31:27] == 5'd8) && (ld_rd != 0) && reads_reg(hz.IR_Decode, ld_rd);
        exp = '0;
        if (m_err)                             exp = M_CAP | M_EXC;
        else if (issuing)                      exp = FREEZE | ((kind == 1) ? M_CMUL : M_CDIV);
        else if (m_wait && !hz.data_resultRDY) exp = FREEZE | M_BSY;
        else if (m_wait)                       exp = M_CAP | M_BSY | (hz.data_exception ? M_EXC : 12'h0);
        else if (hz.br_taken_X)                exp = BRFL;
        else if (lu)                           exp = LDUSE;
        if (m_tmo) exp |= M_TMO;
        if (m_err) m_err = 0;
        else if (issuing) begin
            m_wait = 1; m_cnt = 0;
        end else if (m_wait) begin
            if (hz.data_resultRDY) m_wait = 0;
            else begin
                m_cnt++;
`ifdef MULTDIV_TIMEOUT_EN
                if (m_cnt >= TMO_LIMIT) begin
                    m_wait = 0; m_err = 1; m_tmo = 1;
                end
`endif
            end
        end
    endtask

    function automatic int rreg();
        if ($urandom_range(0, 9) == 0) return 30;
        return int'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        int k, op, alu;
        k = int'($urandom_range(0, 10));
        alu = -1;
        case (k)
            0: begin op = 0; alu = 0; end
            1: begin op = 0; alu = 6; end
            2: begin op = 0; alu = 7; end
            3: op = 8;
            4: op = 7;
            5: op = 5;
            6: op = 2;
            7: op = 6;
            8: op = 4;
            9: op = 22;
            default: op = 1;
        endcase
        ir = $urandom;
        ir = {op[4:0], ir[26:0]};
        ir[26:22] = 5'(rreg());
        ir[21:17] = 5'(rreg());
        ir[16:12] = 5'(rreg());
        if (alu >= 0) ir[6:2] = alu[4:0];
        return ir;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] exp;
        logic [31:0] nop, mul, div, lw5, add_r5, add_r0, lw0;
        nop    = 32'h0;
        mul    = mk(0, 3, 1, 2, 6);
        div    = mk(0, 4, 1, 2, 7);
        lw5    = mk(8, 5, 1, 0, 0);
        lw0    = mk(8, 0, 1, 0, 0);
        add_r5 = mk(0, 6, 5, 2, 0);
        add_r0 = mk(0, 6, 0, 2, 0);

        // outputs forced low while in reset regardless of inputs
        hz.IR_Decode = add_r5; hz.IR_Execute = mul; hz.br_taken_X = 1'b1;
        hz.data_resultRDY = 1'b1; hz.data_exception = 1'b1;
        #12;
        check_eq("reset_hold", outs(), 12'h000);
        hz.IR_Execute = nop; hz.IR_Decode = nop; hz.br_taken_X = 1'b0;
        hz.data_resultRDY = 1'b0; hz.data_exception = 1'b0;
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;

        hz.IR_Execute = lw5; hz.IR_Decode = add_r5;
        cyc("load_use", LDUSE);
        hz.IR_Execute = nop;
        cyc("load_use_one_cycle", 12'h000);
        hz.IR_Execute = lw0; hz.IR_Decode = add_r0;
        cyc("lw_r0_no_stall", 12'h000);
        hz.IR_Execute = lw5; hz.IR_Decode = add_r5; hz.br_taken_X = 1'b1;
        cyc("branch_over_load_use", BRFL);
        hz.br_taken_X = 1'b0; hz.IR_Execute = nop;

        // mul: RDY on the sixth cycle after issue
        hz.IR_Execute = mul;
        cyc("mul_issue", FREEZE | M_CMUL);
        for (int i = 0; i < 5; i++) begin
            hz.br_taken_X = (i == 2);
            cyc($sformatf("mul_busy%0d", i), FREEZE | M_BSY);
        end
        hz.br_taken_X = 1'b0; hz.data_resultRDY = 1'b1;
        cyc("mul_capture", M_CAP | M_BSY);
        hz.data_resultRDY = 1'b0; hz.IR_Execute = nop;
        cyc("mul_back_idle", 12'h000);

        // div with exception, then back-to-back div
        hz.IR_Execute = div;
        cyc("div_issue", FREEZE | M_CDIV);
        cyc("div_busy", FREEZE | M_BSY);
        hz.data_resultRDY = 1'b1; hz.data_exception = 1'b1;
        cyc("div_exc", M_CAP | M_EXC | M_BSY);
        hz.data_resultRDY = 1'b0; hz.data_exception = 1'b0;
        cyc("div_b2b_issue", FREEZE | M_CDIV);
        hz.data_resultRDY = 1'b1;
        cyc("div_b2b_capture", M_CAP | M_BSY);
        hz.data_resultRDY = 1'b0; hz.IR_Execute = nop;
        cyc("div_idle", 12'h000);

        // reset during BUSY cycle 3
        hz.IR_Execute = mul;
        cyc("rst_issue", FREEZE | M_CMUL);
        cyc("rst_busy1", FREEZE | M_BSY);
        cyc("rst_busy2", FREEZE | M_BSY);
        #1 check_eq("rst_busy3", outs(), FREEZE | M_BSY);
        #1 resetn = 1'b0;
        #1 check_eq("rst_async", outs(), 12'h000);
        @(posedge clock); #1;
        hz.IR_Execute = nop; hz.data_resultRDY = 1'b1;
        #1 resetn = 1'b1;
        cyc("stale_rdy", 12'h000);
        cyc("stale_rdy_idle", 12'h000);
        hz.data_resultRDY = 1'b0;

`ifdef MULTDIV_TIMEOUT_EN
        hz.IR_Execute = mul;
        cyc("tmo_issue", FREEZE | M_CMUL);
        for (int i = 0; i < TMO_LIMIT; i++)
            cyc($sformatf("tmo_busy%0d", i), FREEZE | M_BSY);
        hz.IR_Execute = nop;
        cyc("tmo_err", M_CAP | M_EXC | M_TMO);
        cyc("tmo_sticky", M_TMO);
        hz.br_taken_X = 1'b1;
        cyc("tmo_resume", BRFL | M_TMO);
        hz.br_taken_X = 1'b0;
        #2 resetn = 1'b0;
        #1 check_eq("tmo_cleared", outs(), 12'h000);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;
`endif

        model_reset();
        for (int i = 0; i < 3000; i++) begin
            hz.IR_Decode      = rand_ir();
            hz.IR_Execute     = rand_ir();
            hz.br_taken_X     = ($urandom_range(0, 4) == 0);
            hz.data_resultRDY = ($urandom_range(0, 9) < 3);
            hz.data_exception = $urandom_range(0, 1) == 1;
            #4;
            model_step(exp);
            check_eq($sformatf("rand%0d", i), outs(), exp);
            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
